// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port SRAM arbiter giving display reads priority over FIFO-buffered GPU writes.
// Optional VRAM_ARB_SNOOP_EN: a committed write to the currently displayed address also updates o_disp_pixel.
module vram_arbiter #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WFIFO_DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_disp_address,
    output logic [DATA_W-1:0] o_disp_pixel,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_address,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_dq_out,
    output logic              o_sram_dq_oe,
    input  logic [DATA_W-1:0] i_sram_dq_in,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n,
    output logic              o_sram_ub_n,
    output logic              o_sram_lb_n
);
    localparam int PTR_W = $clog2(WFIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, WRITE} slot_t;

    slot_t             state, nxt;
    logic [ADDR_W-1:0] disp_q, last_read_addr;
    logic              last_valid;
    logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
    logic [PTR_W-1:0]  wptr, rptr, head;
    logic [PTR_W:0]    count;
    logic              full, push, pop, read_req, write_avail;

    // The entry being written in the current WRITE slot is still counted until
    // its closing edge, so the next candidate is the one behind it.
    assign pop         = state == WRITE;
    assign full        = count == (PTR_W+1)'(WFIFO_DEPTH);
    assign push        = i_wr_valid && !full;
    assign o_wr_ready  = !full;
    assign head        = rptr + {{(PTR_W-1){1'b0}}, pop};
    assign write_avail = count > {{PTR_W{1'b0}}, pop};
    // A read already in flight for disp_q must not be requested a second time.
    assign read_req    = (disp_q != last_read_addr || !last_valid) &&
                         !(state == READ && o_sram_addr == disp_q);
    assign o_sram_ub_n = 1'b0;
    assign o_sram_lb_n = 1'b0;

    // Display address pipeline stage; also runs during reset so the first read targets a real address.
    always_ff @(posedge i_clk) disp_q <= i_disp_address;

    // Write FIFO storage.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr[wptr] <= i_wr_address;
            fifo_data[wptr] <= i_wr_data;
        end
    end

    // Write FIFO pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + {{(PTR_W-1){1'b0}}, push};
            rptr  <= rptr + {{(PTR_W-1){1'b0}}, pop};
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    // Slot register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= nxt;
    end

    // Slot selection: display reads first, then pending writes.
    always_comb begin
        nxt = IDLE;
        nxt = read_req ? READ : write_avail ? WRITE : IDLE;
    end

    // Registered SRAM strobes, address and write data for the upcoming slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sram_addr   <= '0;
            o_sram_dq_out <= '0;
            o_sram_dq_oe  <= 1'b0;
            o_sram_ce_n   <= 1'b1;
            o_sram_oe_n   <= 1'b1;
            o_sram_we_n   <= 1'b1;
        end else begin
            o_sram_addr   <= nxt == READ ? disp_q : nxt == WRITE ? fifo_addr[head] : o_sram_addr;
            o_sram_dq_out <= nxt == WRITE ? fifo_data[head] : o_sram_dq_out;
            o_sram_dq_oe  <= nxt == WRITE;
            o_sram_ce_n   <= 1'b0;
            o_sram_oe_n   <= nxt != READ;
            o_sram_we_n   <= nxt != WRITE;
        end
    end

    // Capture read data and remember which address the display now shows.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_disp_pixel   <= '0;
            last_read_addr <= '0;
            last_valid     <= 1'b0;
        end else if (state == READ) begin
            o_disp_pixel   <= i_sram_dq_in;
            last_read_addr <= o_sram_addr;
            last_valid     <= 1'b1;
        end
`ifdef VRAM_ARB_SNOOP_EN
        else if (state == WRITE && last_valid && o_sram_addr == last_read_addr) begin
            o_disp_pixel <= o_sram_dq_out;
        end
`endif
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed self-checking bench for vram_arbiter with a behavioural async SRAM.
module tb_vram_arbiter;
    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic [DW-1:0] disp_pixel;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq_out;
    logic          sram_dq_oe;
    logic [DW-1:0] sram_dq_in;
    logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int n_cmp = 0;
    int n_err = 0;

    vram_arbiter dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_disp_address (disp_addr),
        .o_disp_pixel   (disp_pixel),
        .i_wr_valid     (wr_valid),
        .o_wr_ready     (wr_ready),
        .i_wr_address   (wr_addr),
        .i_wr_data      (wr_data),
        .o_sram_addr    (sram_addr),
        .o_sram_dq_out  (sram_dq_out),
        .o_sram_dq_oe   (sram_dq_oe),
        .i_sram_dq_in   (sram_dq_in),
        .o_sram_ce_n    (sram_ce_n),
        .o_sram_oe_n    (sram_oe_n),
        .o_sram_we_n    (sram_we_n),
        .o_sram_ub_n    (sram_ub_n),
        .o_sram_lb_n    (sram_lb_n)
    );

    always #5 clk = ~clk;

    // Power-up contents of the SRAM model for words never written.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 18'h00005) return 16'hF800;
        if (a == 18'h00040) return 16'h1234;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    logic [DW-1:0] mem   [0:(1<<AW)-1];
    bit            wflag [0:(1<<AW)-1];
    int            cyc = 0;
    int            n_wr = 0;
    int            n_rd = 0;
    logic [AW-1:0] log_addr [0:63];
    logic [DW-1:0] log_data [0:63];
    int            log_cyc  [0:63];

    assign sram_dq_in = sram_oe_n ? 16'h0000 :
                        (wflag[sram_addr] ? mem[sram_addr] : init_val(sram_addr));

    // SRAM model: a write commits at the edge that closes a WRITE slot.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!sram_we_n && sram_dq_oe && !sram_ce_n) begin
            mem[sram_addr]   <= sram_dq_out;
            wflag[sram_addr] <= 1'b1;
            if (n_wr < 64) begin
                log_addr[n_wr] <= sram_addr;
                log_data[n_wr] <= sram_dq_out;
                log_cyc[n_wr]  <= cyc;
            end
            n_wr <= n_wr + 1;
        end
        if (!sram_oe_n && !sram_ce_n) n_rd <= n_rd + 1;
    end

    task automatic test_reset();
        int rd0, oe_low;
        rst_n = 1'b0;
        disp_addr = 18'h00005;
        repeat (3) @(negedge clk);
        n_cmp++; if (disp_pixel !== 16'h0000) begin n_err++; $display("FAIL rst_pixel: got %h expected 0000", disp_pixel); end
        n_cmp++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL rst_we_n: got %b expected 1", sram_we_n); end
        n_cmp++; if (sram_oe_n !== 1'b1) begin n_err++; $display("FAIL rst_oe_n: got %b expected 1", sram_oe_n); end
        n_cmp++; if (sram_ce_n !== 1'b1) begin n_err++; $display("FAIL rst_ce_n: got %b expected 1", sram_ce_n); end
        n_cmp++; if ({sram_ub_n, sram_lb_n} !== 2'b00) begin n_err++; $display("FAIL rst_ub_lb: got %b expected 00", {sram_ub_n, sram_lb_n}); end
        n_cmp++; if (sram_dq_oe !== 1'b0) begin n_err++; $display("FAIL rst_dq_oe: got %b expected 0", sram_dq_oe); end
        n_cmp++; if (sram_addr !== 18'h0) begin n_err++; $display("FAIL rst_addr: got %h expected 0", sram_addr); end
        n_cmp++; if (sram_dq_out !== 16'h0) begin n_err++; $display("FAIL rst_dq_out: got %h expected 0", sram_dq_out); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_wr_ready: got %b expected 1", wr_ready); end
        rd0 = n_rd;
        oe_low = 0;
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (!sram_oe_n) oe_low++;
            if (i == 1) begin
                n_cmp++; if (sram_ce_n !== 1'b0) begin n_err++; $display("FAIL ce_after_rst: got %b expected 0", sram_ce_n); end
            end
            if (i == 3) begin
                n_cmp++; if (disp_pixel !== 16'hF800) begin n_err++; $display("FAIL first_pixel: got %h expected f800", disp_pixel); end
            end
        end
        n_cmp++; if (oe_low !== 1) begin n_err++; $display("FAIL first_oe_cycles: got %0d expected 1", oe_low); end
        n_cmp++; if (n_rd - rd0 !== 1) begin n_err++; $display("FAIL first_read_slots: got %0d expected 1", n_rd - rd0); end
        n_cmp++; if (disp_pixel !== 16'hF800) begin n_err++; $display("FAIL pixel_hold: got %h expected f800", disp_pixel); end
    endtask

    task automatic test_interleave();
        int rd0, wr0, bad;
        logic [AW-1:0] a;
        rd0 = n_rd;
        wr0 = n_wr;
        for (int j = 0; j <= 14; j++) begin
            @(negedge clk);
            if (j >= 3 && j % 2 == 1) begin
                a = 18'h00100 + AW'((j - 3) / 2);
                n_cmp++; if (disp_pixel !== init_val(a)) begin n_err++; $display("FAIL il_pixel_k3 @%h: got %h expected %h", a, disp_pixel, init_val(a)); end
            end
            if (j >= 4 && j % 2 == 0) begin
                a = 18'h00100 + AW'((j - 4) / 2);
                n_cmp++; if (disp_pixel !== init_val(a)) begin n_err++; $display("FAIL il_pixel_k4 @%h: got %h expected %h", a, disp_pixel, init_val(a)); end
            end
            if (j % 2 == 0 && j < 12) disp_addr = 18'h00100 + AW'(j / 2);
            wr_valid = j < 4;
            wr_addr  = 18'h20000 + AW'(j);
            wr_data  = 16'h5A00 + DW'(j);
        end
        wr_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++; if (n_rd - rd0 !== 6) begin n_err++; $display("FAIL il_read_slots: got %0d expected 6", n_rd - rd0); end
        n_cmp++; if (n_wr - wr0 !== 4) begin n_err++; $display("FAIL il_write_slots: got %0d expected 4", n_wr - wr0); end
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (log_addr[wr0 + i] !== 18'h20000 + AW'(i) || log_data[wr0 + i] !== 16'h5A00 + DW'(i) ||
                mem[18'h20000 + AW'(i)] !== 16'h5A00 + DW'(i)) bad++;
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL il_write_content: got %0d bad entries expected 0", bad); end
    endtask

    task automatic test_starve(output int wr0);
        int acc;
        wr0 = n_wr;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            disp_addr = 18'h00200 + AW'(i);
            wr_valid  = 1'b1;
            wr_addr   = 18'h30000 + AW'(acc);
            wr_data   = 16'hC000 + DW'(acc);
            if (wr_ready) acc++;
        end
        @(negedge clk);
        n_cmp++; if (acc !== 16) begin n_err++; $display("FAIL starve_accepts: got %0d expected 16", acc); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL starve_ready: got %b expected 0", wr_ready); end
        n_cmp++; if (n_wr - wr0 !== 0) begin n_err++; $display("FAIL starve_writes: got %0d expected 0", n_wr - wr0); end
    endtask

    task automatic test_full_pop(input int wr0);
        int t, bad;
        wr_valid = 1'b1;
        wr_addr  = 18'h3FFFF;
        wr_data  = 16'hDEAD;
        t = 0;
        while (sram_we_n && t < 10) begin @(negedge clk); t++; end
        n_cmp++; if (sram_we_n !== 1'b0) begin n_err++; $display("FAIL fp_write_timeout: got we_n %b expected 0", sram_we_n); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL fp_ready_during_pop: got %b expected 0", wr_ready); end
        @(negedge clk);
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL fp_ready_after_pop: got %b expected 1", wr_ready); end
        wr_valid = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (n_wr - wr0 !== 16) begin n_err++; $display("FAIL drain_count: got %0d expected 16", n_wr - wr0); end
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (log_addr[wr0 + i] !== 18'h30000 + AW'(i) || log_data[wr0 + i] !== 16'hC000 + DW'(i)) bad++;
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL drain_order: got %0d bad entries expected 0", bad); end
        n_cmp++; if (log_cyc[wr0 + 15] - log_cyc[wr0] !== 15) begin n_err++; $display("FAIL drain_consecutive: got span %0d expected 15", log_cyc[wr0 + 15] - log_cyc[wr0]); end
        n_cmp++; if (wflag[18'h3FFFF] !== 1'b0) begin n_err++; $display("FAIL refused_push_written: got %b expected 0", wflag[18'h3FFFF]); end
    endtask

    task automatic test_reset_mid_write();
        int wr0, seen, t;
        wr0 = n_wr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            disp_addr = 18'h00300 + AW'(i);
            wr_valid  = 1'b1;
            wr_addr   = 18'h31000 + AW'(i);
            wr_data   = 16'hE000 + DW'(i);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        seen = 0;
        t = 0;
        while (seen < 3 && t < 20) begin
            @(negedge clk);
            t++;
            if (!sram_we_n) seen++;
        end
        n_cmp++; if (seen !== 3) begin n_err++; $display("FAIL rmw_slot_timeout: got %0d write slots expected 3", seen); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL rmw_we_n: got %b expected 1", sram_we_n); end
        n_cmp++; if (sram_dq_oe !== 1'b0) begin n_err++; $display("FAIL rmw_dq_oe: got %b expected 0", sram_dq_oe); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rmw_ready: got %b expected 1", wr_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (n_wr - wr0 !== 2) begin n_err++; $display("FAIL rmw_commits: got %0d expected 2", n_wr - wr0); end
        n_cmp++; if (mem[18'h31001] !== 16'hE001 || log_addr[wr0] !== 18'h31000) begin n_err++; $display("FAIL rmw_committed_data: got %h expected e001", mem[18'h31001]); end
        n_cmp++; if ({wflag[18'h31002], wflag[18'h31003], wflag[18'h31004]} !== 3'b000) begin n_err++; $display("FAIL rmw_discarded: got %b expected 000", {wflag[18'h31002], wflag[18'h31003], wflag[18'h31004]}); end
    endtask

    task automatic test_snoop();
        int t;
        logic [DW-1:0] exp_px;
`ifdef VRAM_ARB_SNOOP_EN
        exp_px = 16'hABCD;
`else
        exp_px = 16'h1234;
`endif
        @(negedge clk);
        disp_addr = 18'h00040;
        repeat (6) @(negedge clk);
        n_cmp++; if (disp_pixel !== 16'h1234) begin n_err++; $display("FAIL snoop_pre: got %h expected 1234", disp_pixel); end
        wr_valid = 1'b1;
        wr_addr  = 18'h00040;
        wr_data  = 16'hABCD;
        @(negedge clk);
        wr_valid = 1'b0;
        t = 0;
        while (sram_we_n && t < 10) begin @(negedge clk); t++; end
        n_cmp++; if (sram_we_n !== 1'b0) begin n_err++; $display("FAIL snoop_write_timeout: got we_n %b expected 0", sram_we_n); end
        @(negedge clk);
        n_cmp++; if (disp_pixel !== exp_px) begin n_err++; $display("FAIL snoop_pixel: got %h expected %h", disp_pixel, exp_px); end
        n_cmp++; if (mem[18'h00040] !== 16'hABCD) begin n_err++; $display("FAIL snoop_sram: got %h expected abcd", mem[18'h00040]); end
        repeat (4) @(negedge clk);
        n_cmp++; if (disp_pixel !== exp_px) begin n_err++; $display("FAIL snoop_hold: got %h expected %h", disp_pixel, exp_px); end
    endtask

    initial begin
        int wr0;
        test_reset();
        test_interleave();
        test_starve(wr0);
        test_full_pop(wr0);
        test_reset_mid_write();
        test_snoop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
